// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions.
//   state_e       : control states for the bit-serial arithmetic units
//   DEFAULT_WIDTH : default operand width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
//   a, b : operand bits
//   bin  : borrow in
//   diff : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, only honoured in IDLE
//   a, b, bin  : operands and borrow-in, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/bout become valid
//   diff, bout : (a - b - bin) mod 2^WIDTH and final borrow; held until next start
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    count_q, count_d;

  logic cell_diff;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          diff_d  = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Shift/or form rather than a concatenation so WIDTH=1 elaborates.
        diff_d  = (diff_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        brw_d   = cell_bout;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed vectors plus an
// exhaustive WIDTH=2 sweep on a second instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       rst, start, bin, busy, done, bout;
  logic [7:0] a, b, diff;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  // WIDTH=2 instance
  logic       rst2, start2, bin2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    string      name;
  } exp8_t;

  typedef struct {
    logic [2:0] res;
    int         id;
  } exp2_t;

  exp8_t q8[$];
  exp2_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- WIDTH=8 monitor ----------------
  logic  busy_prev = 1'b0, done_prev = 1'b0;
  int    rise8 = 0, busy_cnt = 0, last_done8 = -1, dones8 = 0;
  bit    b2b_mode = 1'b0;
  exp8_t e8;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !busy_prev) begin
        rise8    = cyc;
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
        if (q8.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e8 = q8.pop_front();
          chk({e8.name, "_diff"}, {24'd0, diff}, {24'd0, e8.diff});
          chk({e8.name, "_bout"}, {31'd0, bout}, {31'd0, e8.bout});
          chk({e8.name, "_latency"}, cyc - rise8, 32'd8);
          chk({e8.name, "_busy_cycles"}, busy_cnt, 32'd8);
        end
        if (b2b_mode && last_done8 >= 0) chk("b2b_interval", cyc - last_done8, 32'd10);
        last_done8 = cyc;
        dones8++;
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  // ---------------- WIDTH=2 monitor ----------------
  exp2_t e2;

  always @(negedge clk) begin
    if (!rst2 && done2) begin
      if (q2.size() == 0) begin
        fail_now("w2_unexpected_done");
      end else begin
        e2 = q2.pop_front();
        chk($sformatf("w2_case%0d", e2.id), {29'd0, bout2, diff2}, {29'd0, e2.res});
      end
    end
  end

  // ---------------- WIDTH=8 stimulus ----------------
  task automatic wait_idle8(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q8.size() == 0 && !busy && !done) break;
    end
    if (k == 40) fail_now({name, "_timeout"});
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     input logic [7:0] ediff, input logic ebout, input string name);
    exp8_t e;
    e.diff = ediff; e.bout = ebout; e.name = name;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle8(name);
  endtask

  task automatic run8();
    exp8_t e;
    int    d0, k;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;

    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "5m3");
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "3m5");
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "0m0b1");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FFmFFb1");
    op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "FFm0");
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "80m1");

    // start pulsed during busy and operands changed mid-operation
    d0 = dones8;
    e.diff = 8'h47; e.bout = 1'b0; e.name = "hs";
    @(negedge clk);
    a = 8'h5A; b = 8'h13; bin = 1'b0; start = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    wait_idle8("hs");
    repeat (3) @(negedge clk);
    chk("hs_single_done", dones8 - d0, 32'd1);

    // start held high: one result every WIDTH+2 cycles
    b2b_mode = 1'b1; last_done8 = -1;
    e.diff = 8'hF0; e.bout = 1'b1; e.name = "b2b";
    repeat (3) q8.push_back(e);
    d0 = dones8;
    @(negedge clk);
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dones8 - d0 >= 3) begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    if (k == 60) fail_now("b2b_timeout");
    wait_idle8("b2b");
    b2b_mode = 1'b0;

    // reset during the 4th SHIFT cycle
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff}, 32'd0);
    chk("mid_rst_bout", {31'd0, bout}, 32'd0);
    d0 = dones8;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", dones8 - d0, 32'd0);
    op8(8'h34, 8'h12, 1'b1, 8'h21, 1'b0, "after_rst");
  endtask

  // ---------------- WIDTH=2 stimulus ----------------
  task automatic run2();
    exp2_t      e;
    logic [4:0] v;
    int         r, k;
    rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = i[4:0];
      r = (int'(v[4:3]) - int'(v[2:1]) - int'(v[0])) & 7;
      e.res = r[2:0];
      e.id  = i;
      @(negedge clk);
      a2 = v[4:3]; b2 = v[2:1]; bin2 = v[0]; start2 = 1'b1;
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (q2.size() == 0 && !busy2 && !done2) break;
      end
      if (k == 20) fail_now("w2_timeout");
    end
  endtask

  initial begin
    fork
      run8();
      run2();
    join
    if (q8.size() != 0) fail_now("w8_leftover_expectations");
    if (q2.size() != 0) fail_now("w2_leftover_expectations");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
